// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and FSM state encoding for the VRAM responder.
package vram_pkg;
    localparam int VRAM_DATA_W = 16;
    localparam int VRAM_ADDR_W = 32;
    localparam int VRAM_MASK_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} vram_state_e;
endpackage

// File: rtl/vram_bram.sv
// vram_bram: single-port DEPTHx16 block RAM with byte write enables and registered read.
module vram_bram
    import vram_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [1:0]             be_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [VRAM_DATA_W-1:0] wdata_i,
    output logic [VRAM_DATA_W-1:0] rdata_o
);
    logic [VRAM_DATA_W-1:0] mem_q [DEPTH];
    logic [VRAM_DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en_i && we_i && be_i[0]) mem_q[addr_i][7:0] <= wdata_i[7:0];
        if (en_i && we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        if (en_i && !we_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/vram_responder.sv
// vram_responder: VRAM bus responder serving single-word requests from a block-RAM framebuffer.
// Define VRAM_RESP_ERR_EN to add the sticky out-of-range flag err_o and its clear err_clr_i.
module vram_responder
    import vram_pkg::*;
#(
    parameter int FB_WIDTH    = 128,
    parameter int FB_HEIGHT   = 128,
    parameter int DEPTH       = FB_WIDTH * FB_HEIGHT,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic                   vram_sel_i,
    input  logic                   vram_wr_i,
    input  logic [VRAM_MASK_W-1:0] vram_mask_i,
    input  logic [VRAM_ADDR_W-1:0] vram_addr_i,
    input  logic [VRAM_DATA_W-1:0] vram_data_in_i,
    output logic                   vram_ack_o,
    output logic [VRAM_DATA_W-1:0] vram_data_out_o
`ifdef VRAM_RESP_ERR_EN
    ,
    output logic                   err_o,
    input  logic                   err_clr_i
`endif
);
    localparam int AW = $clog2(DEPTH);
    vram_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [1:0]             be_q, be_d;
    logic [VRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic                   zero_q;
    logic                   in_range;
    logic                   access;
    logic [VRAM_DATA_W-1:0] ram_rdata;
    logic                   unused_mask;
    assign unused_mask = ^vram_mask_i[VRAM_MASK_W-1:2];
    assign in_range    = addr_q < VRAM_ADDR_W'(DEPTH);
    assign access      = state_q == ACCESS;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: if (vram_sel_i) begin
                addr_d  = vram_addr_i;
                wr_d    = vram_wr_i;
                be_d    = vram_mask_i[1:0];
                wdata_d = vram_data_in_i;
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
            end
            ACCESS: state_d = ACK;
            ACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            // The RAM read register is not reset; this flag forces 0 until a valid read lands
            if (access && !wr_q) zero_q <= !in_range;
        end
    end
    vram_bram #(.DEPTH(DEPTH)) u_bram (
        .clk     (clk),
        .en_i    (access && in_range),
        .we_i    (wr_q),
        .be_i    (be_q),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );
    assign vram_ack_o      = state_q == ACK;
    assign vram_data_out_o = zero_q ? '0 : ram_rdata;
`ifdef VRAM_RESP_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) err_q <= 1'b0;
        else err_q <= (access && !in_range) || (err_q && !err_clr_i);
    end
    assign err_o = err_q;
`endif
endmodule
